imu_telemetry_tx: RTL

Transmit-side counterpart to the UART receive path and IMU packet parser. On a send request, it snapshots the six integrator outputs (vx, vy, vz, gx_cal, gy_cal, gz_cal) and frames them into a fixed 27-byte packet. It then serializes the packet as 8N1 UART on a single output pin, e.g. a GPIO back to the STM32 or UART_TXD. Packet framing and bit-level serialization live in this one block.

---
 rtl/imu_telemetry_tx.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/imu_telemetry_tx.sv
// Frames a snapshot of six 32-bit integrator outputs into a 27-byte packet and sends it as 8N1 UART, LSB first.
// Latency: start bit of the first header byte is driven on the edge that accepts start; a frame lasts 270*CLKS_PER_BIT cycles.
// Backpressure: no queueing; a start seen while busy is dropped and flagged with a one-cycle overrun pulse.
module imu_telemetry_tx #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [7:0]  HDR0         = 8'hAA,
    parameter logic [7:0]  HDR1         = 8'h55
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] vx,
    input  logic [31:0] vy,
    input  logic [31:0] vz,
    input  logic [31:0] gx,
    input  logic [31:0] gy,
    input  logic [31:0] gz,
    output logic        tx_serial,
    output logic        busy,
    output logic        done,
    output logic        overrun
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [BAUD_W-1:0]   r_baud;
    logic [2:0]          r_bit_idx;
    logic [4:0]          r_byte_idx;
    logic [191:0]        r_payload;
    logic [7:0]          r_csum;
    logic                r_tx;
    logic                r_done;
    logic                r_overrun;

    logic [191:0]        w_in_payload;
    logic [7:0]          w_csum_in;
    logic [7:0]          w_cur_byte;
    logic                w_bit_end;
    logic                w_last_byte;
    logic                w_accept;
    logic                w_tx_next;
    logic                w_done_next;
    logic                w_overrun_next;

    // Payload order on the wire is vx first, so vx sits in the low bits.
    assign w_in_payload = {gz, gy, gx, vz, vy, vx};
    assign w_bit_end    = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
    assign w_last_byte  = (r_byte_idx == 5'd26);
    assign w_accept     = start && (r_state == S_IDLE);

    // Checksum over the 24 payload bytes, taken from the live inputs so it lands together with the snapshot.
    always_comb begin
        w_csum_in = 8'h00;
        for (int i = 0; i < 24; i++) begin
            w_csum_in = w_csum_in + w_in_payload[i*8 +: 8];
        end
    end

    // Select the byte currently on the wire: two headers, 24 snapshot bytes, then the checksum.
    always_comb begin
        w_cur_byte = 8'h00;
        if (r_byte_idx == 5'd0) begin
            w_cur_byte = HDR0;
        end else if (r_byte_idx == 5'd1) begin
            w_cur_byte = HDR1;
        end else if (w_last_byte) begin
            w_cur_byte = r_csum;
        end else begin
            for (int i = 0; i < 24; i++) begin
                if (r_byte_idx == 5'(i + 2)) begin
                    w_cur_byte = r_payload[i*8 +: 8];
                end
            end
        end
    end

    // State register plus the registered line, done and overrun outputs; reset forces the line idle at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_tx      <= w_tx_next;
            r_done    <= w_done_next;
            r_overrun <= w_overrun_next;
        end
    end

    // Next-state: start bit, eight data bits, stop bit, repeated per byte until the checksum byte ends.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_next = S_START;
            end
            S_START: begin
                if (w_bit_end) w_state_next = S_DATA;
            end
            S_DATA: begin
                if (w_bit_end && (r_bit_idx == 3'd7)) w_state_next = S_STOP;
            end
            S_STOP: begin
                if (w_bit_end) w_state_next = w_last_byte ? S_IDLE : S_START;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Output decode: value the line takes for the next bit cell, end-of-frame pulse, rejected-start pulse.
    always_comb begin
        w_tx_next      = r_tx;
        w_done_next    = 1'b0;
        w_overrun_next = start && (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                w_tx_next = w_accept ? 1'b0 : 1'b1;
            end
            S_START: begin
                if (w_bit_end) w_tx_next = w_cur_byte[0];
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_tx_next = (r_bit_idx == 3'd7) ? 1'b1 : w_cur_byte[r_bit_idx + 3'd1];
                end
            end
            S_STOP: begin
                if (w_bit_end) begin
                    // Next byte's start bit follows immediately; after the checksum the line stays high.
                    w_tx_next   = w_last_byte ? 1'b1 : 1'b0;
                    w_done_next = w_last_byte;
                end
            end
            default: w_tx_next = 1'b1;
        endcase
    end

    // Datapath: snapshot and checksum on acceptance, then baud, bit and byte counters while a frame is in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_baud     <= '0;
            r_bit_idx  <= 3'd0;
            r_byte_idx <= 5'd0;
            r_payload  <= '0;
            r_csum     <= 8'h00;
        end else if (w_accept) begin
            r_payload  <= w_in_payload;
            r_csum     <= w_csum_in;
            r_baud     <= '0;
            r_bit_idx  <= 3'd0;
            r_byte_idx <= 5'd0;
        end else if (r_state != S_IDLE) begin
            if (w_bit_end) begin
                r_baud <= '0;
                // Bit index wraps from 7 back to 0 on its own, ready for the next byte.
                if (r_state == S_DATA) r_bit_idx <= r_bit_idx + 3'd1;
                if (r_state == S_STOP) r_byte_idx <= w_last_byte ? 5'd0 : r_byte_idx + 5'd1;
            end else begin
                r_baud <= r_baud + BAUD_W'(1);
            end
        end
    end

    assign tx_serial = r_tx;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign overrun   = r_overrun;

endmodule
